svga_timing_gen: RTL and testbench
==================================

Name: svga_timing_gen

Overview:
- Consumes the pixel clock and the active-high DCM-lock reset from the clock generator.
- Produces SVGA raster timing: hsync, vsync, blank, pixel/line coordinates, line/frame start strobes and a frame counter.
- Downstream pixel-data blocks (character renderer, framebuffer reader) key off these outputs.
- Single clock domain; every output is registered.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync asserted level (0 = active-low)
V_SYNC_POL, 0, vsync asserted level (0 = active-low)
CW, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be at most 2^CW

Ports:
pixel_clock  in  1  pixel clock; all logic rises on this edge
reset  in  1  asynchronous, active-high; held while the DCM is unlocked
hsync  out  1  horizontal sync at H_SYNC_POL polarity
vsync  out  1  vertical sync at V_SYNC_POL polarity
blank  out  1  1 outside the active region
pixel_x  out  CW  horizontal position, 0..H_TOTAL-1
pixel_y  out  CW  vertical position, 0..V_TOTAL-1
line_start  out  1  one-cycle pulse when pixel_x==0
frame_start  out  1  one-cycle pulse when pixel_x==0 and pixel_y==0
frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt:
  - h_cnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOTAL-1 -> 0 when h_cnt and v_cnt both wrap.
- Output stage: registers decoded from (h_cnt, v_cnt). Outputs lag the counters by exactly 1 cycle and are mutually aligned.
- Decode rules, for position (x, y):
  - blank = !(x < H_ACTIVE && y < V_ACTIVE)
  - hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; it changes only together with x==0
  - line_start = (x==0); frame_start = (x==0 && y==0)
- frame_count increments on the same output edge that frame_start goes high, except for the first frame_start after reset.
- Reset (asynchronous; takes effect immediately at any point mid-frame):
  - h_cnt = v_cnt = 0
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL (deasserted)
  - blank = 1, pixel_x = 0, pixel_y = 0
  - line_start = 0, frame_start = 0, frame_count = 0
- First rising edge after reset release:
  - counters -> (1,0)
  - outputs show (0,0): blank=0, line_start=1, frame_start=1, frame_count stays 0
- Wrap boundary: x = H_TOTAL-1, y = V_TOTAL-1 is followed directly by (0,0), with no idle cycle. Period is exactly H_TOTAL*V_TOTAL cycles.
- Coordinate arithmetic is unsigned CW-bit; no overflow is possible given the CW constraint.
- No enable input: the block runs freely whenever reset is low.

Test Plan:
- Reset release: hold reset 10 cycles, then release. While in reset: blank=1, hsync=vsync=1, pixel_x=pixel_y=0. On first edge after release: frame_start=1, line_start=1, blank=0, frame_count=0.
- Horizontal timing with defaults: hsync low exactly for pixel_x 656..751 (96 cycles); blank rises at pixel_x=640; line_start period 800 cycles.
- Vertical timing: vsync low exactly for pixel_y 490..491 (1600 cycles), with edges coincident with line_start; blank=1 for all pixel_y >= 480.
- Frame period and counter: frame_start pulses every 420000 cycles. frame_count reads 1 after the second frame_start, and wraps 255->0 after 257 frame_starts.
- Mid-frame reset: assert reset asynchronously at (300,200). Outputs take reset values before the next edge. After release, timing restarts at (0,0) with frame_count=0.
- Polarity/geometry override: H_SYNC_POL=1, V_SYNC_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88. hsync high for pixel_x 840..967; line period 1056 cycles.

Source files
------------

// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator: free-running h/v counters followed by one
// registered decode stage, so all outputs are mutually aligned.
module svga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 11
) (
  input  logic          pixel_clock,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so an end bound equal to 2^CW still compares correctly
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          r_frame_seen;

  logic [CW:0] w_h_ext;
  logic [CW:0] w_v_ext;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_sync;
  logic        w_v_sync;
  logic        w_line_0;
  logic        w_frame_0;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_h_ext   = {1'b0, r_h_cnt};
  assign w_v_ext   = {1'b0, r_v_cnt};
  assign w_h_act   = w_h_ext < H_ACT_END;
  assign w_v_act   = w_v_ext < V_ACT_END;
  assign w_h_sync  = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
  assign w_v_sync  = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);
  assign w_line_0  = (r_h_cnt == '0);
  assign w_frame_0 = w_line_0 && (r_v_cnt == '0);

  // The first frame_start after reset is not a completed frame, so it only arms the counter
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      blank        <= 1'b1;
      pixel_x      <= '0;
      pixel_y      <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
      r_frame_seen <= 1'b0;
    end else begin
      hsync       <= w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      blank       <= ~(w_h_act && w_v_act);
      pixel_x     <= r_h_cnt;
      pixel_y     <= r_v_cnt;
      line_start  <= w_line_0;
      frame_start <= w_frame_0;
      if (w_frame_0) begin
        if (r_frame_seen) frame_count <= frame_count + 1'b1;
        r_frame_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svga_timing_gen.sv
// Bench for svga_timing_gen: default, small-geometry and polarity-override
// instances checked every cycle against an arithmetic raster model.
module tb_svga_timing_gen;

  logic pixel_clock = 1'b0;
  logic reset = 1'b1;

  always #5 pixel_clock = ~pixel_clock;

  logic a_hs, a_vs, a_bl, a_ls, a_fs;
  logic [10:0] a_x, a_y;
  logic [7:0] a_fc;
  logic b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [10:0] b_x, b_y;
  logic [7:0] b_fc;
  logic c_hs, c_vs, c_bl, c_ls, c_fs;
  logic [10:0] c_x, c_y;
  logic [7:0] c_fc;

  svga_timing_gen u_a (
    .pixel_clock(pixel_clock), .reset(reset), .hsync(a_hs), .vsync(a_vs), .blank(a_bl),
    .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

  svga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .pixel_clock(pixel_clock), .reset(reset), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
    .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

  svga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_c (
    .pixel_clock(pixel_clock), .reset(reset), .hsync(c_hs), .vsync(c_vs), .blank(c_bl),
    .pixel_x(c_x), .pixel_y(c_y), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

  localparam int FB = 150;

  int n_total = 0;
  int n_pass  = 0;
  int k = 0;

  // Expected outputs after the k-th rising edge since reset release (k==0: in reset)
  function automatic logic [34:0] model(int ha, int hfp, int hs, int hbp,
                                        int va, int vfp, int vs, int vbp,
                                        bit hp, bit vp, int kk);
    int ht = ha + hfp + hs + hbp;
    int vt = va + vfp + vs + vbp;
    int f  = ht * vt;
    int p, x, y;
    logic hsy, vsy, bl, ls, fs;
    logic [7:0] fc;
    if (kk == 0) return {~hp, ~vp, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 8'd0};
    p   = (kk - 1) % f;
    x   = p % ht;
    y   = p / ht;
    hsy = (x >= ha + hfp && x < ha + hfp + hs) ? hp : ~hp;
    vsy = (y >= va + vfp && y < va + vfp + vs) ? vp : ~vp;
    bl  = !(x < ha && y < va);
    ls  = (x == 0);
    fs  = (x == 0 && y == 0);
    fc  = 8'(((kk - 1) / f) % 256);
    return {hsy, vsy, bl, 11'(x), 11'(y), ls, fs, fc};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a"}, {a_hs, a_vs, a_bl, a_x, a_y, a_ls, a_fs, a_fc},
        model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, k));
    chk({tag, "_b"}, {b_hs, b_vs, b_bl, b_x, b_y, b_ls, b_fs, b_fc},
        model(8, 2, 3, 2, 6, 1, 2, 1, 1'b0, 1'b0, k));
    chk({tag, "_c"}, {c_hs, c_vs, c_bl, c_x, c_y, c_ls, c_fs, c_fc},
        model(800, 40, 128, 88, 4, 1, 2, 1, 1'b1, 1'b1, k));
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    if (reset) k = 0;
    else k++;
    check_all("cyc");
  endtask

  initial begin
    int hold, n, lo_a, ls_a, hi_c, ls_c;

    reset = 1'b1;
    hold = 10 + $urandom_range(0, 5);
    repeat (hold) tick();
    chk("rst_blank", 35'(b_bl), 35'(1));
    chk("rst_hsync", 35'(a_hs), 35'(1));
    chk("rst_vsync", 35'(a_vs), 35'(1));
    chk("rst_xy", 35'({b_x, b_y}), 35'(0));

    reset = 1'b0;
    tick();
    chk("first_fs", 35'(b_fs), 35'(1));
    chk("first_ls", 35'(a_ls), 35'(1));
    chk("first_blank", 35'(a_bl), 35'(0));
    chk("first_fc", 35'(b_fc), 35'(0));

    while (k < 1 + FB) tick();
    chk("fc_second_fs", 35'({b_fs, b_fc}), 35'({1'b1, 8'd1}));

    while (k < 1 + 256 * FB) tick();
    chk("fc_wrap", 35'({b_fs, b_fc}), 35'({1'b1, 8'd0}));

    lo_a = 0; ls_a = 0; hi_c = 0; ls_c = 0;
    for (int i = 0; i < 1056; i++) begin
      tick();
      if (i < 800) begin
        if (!a_hs) lo_a++;
        if (a_ls) ls_a++;
      end
      if (c_hs) hi_c++;
      if (c_ls) ls_c++;
    end
    chk("a_hsync_low_per_line", 35'(lo_a), 35'(96));
    chk("a_line_starts_per_800", 35'(ls_a), 35'(1));
    chk("c_hsync_high_per_line", 35'(hi_c), 35'(128));
    chk("c_line_starts_per_1056", 35'(ls_c), 35'(1));

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(20, 400);
      repeat (n) tick();
      #1 reset = 1'b1;
      #1;
      k = 0;
      check_all("async_rst");
      hold = $urandom_range(1, 5);
      repeat (hold) tick();
      reset = 1'b0;
      tick();
      chk("restart_fs", 35'({b_fs, b_ls, b_fc}), 35'({1'b1, 1'b1, 8'd0}));
      chk("restart_xy", 35'({a_x, a_y}), 35'(0));
    end

    repeat (2 * FB + 37) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
